// File: rtl/apb_gpio_arbiter_pkg.sv
// Shared types and default constants for the two-port APB GPIO arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int ADDR_W_DEF      = 4;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 16;
  localparam int TO_W            = $clog2(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/apb_gpio_arbiter_if.sv
// Requester-side and APB-side signal bundle of the GPIO arbiter.
interface apb_gpio_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic                rsp_valid;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;

  // Arbiter side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  // Requesters plus GPIO slave side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_gpio_arbiter_rr_arb2.sv
// Two-input round-robin grant: on contention the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] |  last_grant);
  assign gnt[1] = req[1] & (~req[0] | ~last_grant);
endmodule

// File: rtl/apb_gpio_arbiter.sv
// Shares one APB GPIO slave between two requesters, one transfer outstanding at a time.
// Optional ACCESS wait-state timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_gpio_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_gpio_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  logic [1:0]          gnt;
  logic                gnt_id, accept, done, timeout;
  logic                psel, penable;
  logic                last_grant_q, owner_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q, rdata_q;
  logic                rsp_valid_q, rsp_id_q, rsp_err_q;

  rr_arb2 u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign gnt_id = gnt[1];
  assign accept = (state_q == IDLE) && (|bus.req_valid);
  assign done   = (state_q == ACCESS) && bus.PREADY;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt_q;

  // Counts PREADY-low ACCESS cycles already spent; the limit hits on the TIMEOUT_CYC-th one.
  assign timeout = (state_q == ACCESS) && !bus.PREADY &&
                   (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !bus.PREADY) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  wire unused_timeout_cyc = (TIMEOUT_CYC > 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    psel    = 1'b0;
    penable = 1'b0;
    unique case (state_q)
      IDLE:   if (|bus.req_valid) state_d = SETUP;
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (done || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= done || timeout;
      if (accept) begin
        last_grant_q <= gnt_id;
        owner_q      <= gnt_id;
      end
      if (done || timeout) begin
        rsp_id_q  <= owner_q;
        rsp_err_q <= timeout;
      end
    end
  end

  // Request fields are captured on accept and held through IDLE until the next grant.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        pwrite_q <= gnt_id ? bus.req_write[1] : bus.req_write[0];
        paddr_q  <= gnt_id ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        pwdata_q <= gnt_id ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      end
      if (timeout) begin
        rdata_q <= '0;
      end else if (done) begin
        rdata_q <= pwrite_q ? '0 : bus.PRDATA;
      end
    end
  end

  assign bus.req_ready = (accept && !PRESET) ? gnt : 2'b00;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;

endmodule
